// File: rtl/ring_router_pkg.sv
// Shared definitions for the VC ring router: port indices, default header layout, routing rule.
// Latency: none (types, constants and a pure combinational function).
// Backpressure: not applicable.
package ring_router_pkg;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] PORT_CW  = 2'd0;
  localparam logic [1:0] PORT_CCW = 2'd1;
  localparam logic [1:0] PORT_PE  = 2'd2;

  // Default header layout of a ring packet
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_DIR_BIT = 62;
  localparam int DEF_HOP_HI  = 55;
  localparam int DEF_HOP_LO  = 48;

  // Routing decision for one FIFO head: where it goes and whether its hop count is consumed
  typedef struct packed {
    logic [1:0] dst;
    logic       hop_dec;
  } route_t;

  // Ring traffic with hops left continues in its direction (one hop consumed);
  // ring traffic with no hops left ejects to the PE; PE traffic enters the ring untouched.
  function automatic route_t route(input logic dir, input logic hop_zero, input logic [1:0] src);
    route_t r;
    r.dst     = dir ? PORT_CCW : PORT_CW;
    r.hop_dec = 1'b0;
    if (src != PORT_PE) begin
      if (hop_zero) r.dst = PORT_PE;
      else          r.hop_dec = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/router_vc_fifo.sv
// Per-input, per-VC packet buffer of DEPTH entries with head-of-queue visibility.
// Latency: a push is visible at o_head the cycle after; a pop frees the slot the cycle after.
// Backpressure: o_full blocks further pushes; pushes when full and pops when empty are ignored.
module router_vc_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_dat;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ring_router_vc.sv
// Ring node router, 3 inputs x 3 outputs, two polarity-multiplexed VCs, round-robin output arbitration.
// Latency: packet accepted in cycle t leaves at the earliest in cycle t+2 (same polarity).
// Backpressure: ri drops only while the link-VC FIFO is full; ro=0 holds the output register.
// Optional ROUTER_STATS_EN adds per-output forward and stall counters.
module ring_router_vc
  import ring_router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DIR_BIT   = DEF_DIR_BIT,
  parameter int HOP_HI    = DEF_HOP_HI,
  parameter int HOP_LO    = DEF_HOP_LO,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              polarity,
  input  logic              cwsi,
  input  logic              ccwsi,
  input  logic              pesi,
  output logic              cwri,
  output logic              ccwri,
  output logic              peri,
  input  logic [DATA_W-1:0] cwdi,
  input  logic [DATA_W-1:0] ccwdi,
  input  logic [DATA_W-1:0] pedi,
  output logic              cwso,
  output logic              ccwso,
  output logic              peso,
  input  logic              cwro,
  input  logic              ccwro,
  input  logic              pero,
  output logic [DATA_W-1:0] cwdo,
  output logic [DATA_W-1:0] ccwdo,
  output logic [DATA_W-1:0] pedo
`ifdef ROUTER_STATS_EN
  ,
  output logic [31:0]       fwd_cnt_cw,
  output logic [31:0]       fwd_cnt_ccw,
  output logic [31:0]       fwd_cnt_pe,
  output logic [31:0]       stall_cnt_cw,
  output logic [31:0]       stall_cnt_ccw,
  output logic [31:0]       stall_cnt_pe
`endif
);

  logic              w_si    [NUM_PORTS];
  logic [DATA_W-1:0] w_di    [NUM_PORTS];
  logic              w_ro    [NUM_PORTS];

  logic              w_push  [NUM_PORTS][2];
  logic              w_pop   [NUM_PORTS][2];
  logic              w_full  [NUM_PORTS][2];
  logic              w_empty [NUM_PORTS][2];
  logic [DATA_W-1:0] w_head  [NUM_PORTS][2];

  logic              r_pol;
  logic              w_av;

  route_t            w_rt    [NUM_PORTS];
  logic              w_hvld  [NUM_PORTS];
  logic [1:0]        w_dst   [NUM_PORTS];
  logic [DATA_W-1:0] w_rpkt  [NUM_PORTS];

  logic              w_gnt_vld [NUM_PORTS];
  logic [1:0]        w_gnt_idx [NUM_PORTS];

  logic              r_ofull [NUM_PORTS][2];
  logic [DATA_W-1:0] r_oreg  [NUM_PORTS][2];
  logic [1:0]        r_ptr   [NUM_PORTS][2];
  logic [DATA_W-1:0] r_dlast [NUM_PORTS];
  logic              w_so    [NUM_PORTS];
  logic [DATA_W-1:0] w_do    [NUM_PORTS];

  assign w_si[PORT_CW]  = cwsi;
  assign w_si[PORT_CCW] = ccwsi;
  assign w_si[PORT_PE]  = pesi;
  assign w_di[PORT_CW]  = cwdi;
  assign w_di[PORT_CCW] = ccwdi;
  assign w_di[PORT_PE]  = pedi;
  assign w_ro[PORT_CW]  = cwro;
  assign w_ro[PORT_CCW] = ccwro;
  assign w_ro[PORT_PE]  = pero;

  // The VC not on the link this cycle is the one being arbitrated
  assign w_av = ~r_pol;

  genvar gi, gv;
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
    for (gv = 0; gv < 2; gv++) begin : g_vc
      router_vc_fifo #(.W(DATA_W), .DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push[gi][gv]),
        .i_dat   (w_di[gi]),
        .i_pop   (w_pop[gi][gv]),
        .o_full  (w_full[gi][gv]),
        .o_empty (w_empty[gi][gv]),
        .o_head  (w_head[gi][gv])
      );
    end
  end

  // Route every arbitration-VC head and build its outgoing (hop-rewritten) form
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_hvld[i] = !w_empty[i][w_av];
      w_rt[i]   = route(w_head[i][w_av][DIR_BIT], w_head[i][w_av][HOP_HI:HOP_LO] == '0, 2'(i));
      w_dst[i]  = w_rt[i].dst;
      w_rpkt[i] = w_head[i][w_av];
      if (w_rt[i].hop_dec)
        w_rpkt[i][HOP_HI:HOP_LO] = w_head[i][w_av][HOP_HI:HOP_LO] - 1'b1;
    end
  end

  // Round-robin grant per output among heads that target it; pushes go to the link VC
  always_comb begin
    int c;
    c = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_gnt_vld[o] = 1'b0;
      w_gnt_idx[o] = PORT_CW;
      if (!r_ofull[o][w_av]) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          c = int'(r_ptr[o][w_av]) + k;
          if (c >= NUM_PORTS) c = c - NUM_PORTS;
          if (!w_gnt_vld[o] && w_hvld[c] && (w_dst[c] == 2'(o))) begin
            w_gnt_vld[o] = 1'b1;
            w_gnt_idx[o] = 2'(c);
          end
        end
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int v = 0; v < 2; v++) begin
        w_push[i][v] = w_si[i] && (r_pol == 1'(v)) && !w_full[i][v];
        w_pop[i][v]  = 1'b0;
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_gnt_vld[o] && (w_gnt_idx[o] == 2'(i))) w_pop[i][w_av] = 1'b1;
      end
    end
  end

  // Link side: the link-VC register drains when downstream is ready; data lines hold otherwise
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_so[o] = r_ofull[o][r_pol] && w_ro[o];
      w_do[o] = w_so[o] ? r_oreg[o][r_pol] : r_dlast[o];
    end
  end

  // Polarity, output registers and round-robin pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pol <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_dlast[o] <= '0;
        for (int v = 0; v < 2; v++) begin
          r_ofull[o][v] <= 1'b0;
          r_ptr[o][v]   <= PORT_CW;
        end
      end
    end else begin
      r_pol <= ~r_pol;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_so[o]) begin
          r_ofull[o][r_pol] <= 1'b0;
          r_dlast[o]        <= r_oreg[o][r_pol];
        end
        if (w_gnt_vld[o]) begin
          r_ofull[o][w_av] <= 1'b1;
          r_oreg[o][w_av]  <= w_rpkt[w_gnt_idx[o]];
          r_ptr[o][w_av]   <= (w_gnt_idx[o] == PORT_PE) ? PORT_CW : w_gnt_idx[o] + 2'd1;
        end
      end
    end
  end

  assign polarity = r_pol;
  assign cwri     = !w_full[PORT_CW][r_pol];
  assign ccwri    = !w_full[PORT_CCW][r_pol];
  assign peri     = !w_full[PORT_PE][r_pol];
  assign cwso     = w_so[PORT_CW];
  assign ccwso    = w_so[PORT_CCW];
  assign peso     = w_so[PORT_PE];
  assign cwdo     = w_do[PORT_CW];
  assign ccwdo    = w_do[PORT_CCW];
  assign pedo     = w_do[PORT_PE];

`ifdef ROUTER_STATS_EN
  logic [31:0] r_fwd   [NUM_PORTS];
  logic [31:0] r_stall [NUM_PORTS];

  // Per-output sends and cycles lost to a full link register facing ro=0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_fwd[o]   <= '0;
        r_stall[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_so[o]) r_fwd[o] <= r_fwd[o] + 32'd1;
        if (r_ofull[o][r_pol] && !w_ro[o]) r_stall[o] <= r_stall[o] + 32'd1;
      end
    end
  end

  assign fwd_cnt_cw    = r_fwd[PORT_CW];
  assign fwd_cnt_ccw   = r_fwd[PORT_CCW];
  assign fwd_cnt_pe    = r_fwd[PORT_PE];
  assign stall_cnt_cw  = r_stall[PORT_CW];
  assign stall_cnt_ccw = r_stall[PORT_CCW];
  assign stall_cnt_pe  = r_stall[PORT_PE];
`endif

endmodule

// File: tb/tb_ring_router_vc.sv
// Bench for ring_router_vc: directed scenarios plus random traffic against a queue-based model.
// Latency: outputs sampled on the falling edge, inputs driven just after the rising edge.
// Backpressure: ready lines driven both directed and random.
module tb_ring_router_vc;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  si;
  logic [63:0] di [3];
  logic [2:0]  ro;
  wire         pol;
  wire  [2:0]  ri;
  wire  [2:0]  so;
  wire  [63:0] dout [3];
`ifdef ROUTER_STATS_EN
  wire  [31:0] fwd [3];
  wire  [31:0] stall [3];
`endif

  always #5 clk = ~clk;

  ring_router_vc #(.BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst), .polarity(pol),
    .cwsi(si[0]), .ccwsi(si[1]), .pesi(si[2]),
    .cwri(ri[0]), .ccwri(ri[1]), .peri(ri[2]),
    .cwdi(di[0]), .ccwdi(di[1]), .pedi(di[2]),
    .cwso(so[0]), .ccwso(so[1]), .peso(so[2]),
    .cwro(ro[0]), .ccwro(ro[1]), .pero(ro[2]),
    .cwdo(dout[0]), .ccwdo(dout[1]), .pedo(dout[2])
`ifdef ROUTER_STATS_EN
    , .fwd_cnt_cw(fwd[0]), .fwd_cnt_ccw(fwd[1]), .fwd_cnt_pe(fwd[2])
    , .stall_cnt_cw(stall[0]), .stall_cnt_ccw(stall[1]), .stall_cnt_pe(stall[2])
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state: FIFO contents as arrays, output slots, RR pointers
  bit          mpol;
  int          mcnt  [3][2];
  logic [63:0] mbuf  [3][2][DEPTH];
  bit          mov   [3][2];
  logic [63:0] mdat  [3][2];
  int          mptr  [3][2];
  logic [63:0] mlast [3];
  logic [31:0] mfwd  [3];
  logic [31:0] mstall[3];

  logic [63:0] log0 [$];
  int          n_deliv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] mkpkt(input bit dir, input logic [7:0] hop, input logic [31:0] tag);
    return {1'b0, dir, 6'd0, hop, 16'd0, tag};
  endfunction

  // Ring packets: hop 0 ejects, else forward with one fewer hop; PE packets enter the ring as-is
  function automatic void mroute(input logic [63:0] p, input int src, output int dst, output logic [63:0] q);
    logic [7:0] hop;
    hop = p[55:48];
    q   = p;
    dst = p[62] ? 1 : 0;
    if (src != 2) begin
      if (hop == 8'd0) dst = 2;
      else q = {p[63:56], 8'(hop - 8'd1), p[47:0]};
    end
  endfunction

  task automatic model_reset();
    mpol = 1'b0;
    for (int o = 0; o < 3; o++) begin
      mlast[o] = '0; mfwd[o] = '0; mstall[o] = '0;
      for (int v = 0; v < 2; v++) begin
        mcnt[o][v] = 0; mov[o][v] = 1'b0; mptr[o][v] = 0;
      end
    end
  endtask

  task automatic model_step();
    int p, a, d, g;
    bit hv [3];
    int hd [3];
    logic [63:0] hq [3];
    if (rst) begin
      model_reset();
      return;
    end
    p = int'(mpol);
    a = 1 - p;
    for (int o = 0; o < 3; o++) begin
      if (mov[o][p] && !ro[o]) mstall[o] = mstall[o] + 1;
      if (mov[o][p] && ro[o]) begin
        mfwd[o]   = mfwd[o] + 1;
        mov[o][p] = 1'b0;
        mlast[o]  = mdat[o][p];
      end
    end
    for (int i = 0; i < 3; i++) begin
      hv[i] = mcnt[i][a] > 0;
      mroute(mbuf[i][a][0], i, hd[i], hq[i]);
    end
    for (int o = 0; o < 3; o++) begin
      g = -1;
      if (!mov[o][a])
        for (int k = 2; k >= 0; k--)
          if (hv[(mptr[o][a] + k) % 3] && hd[(mptr[o][a] + k) % 3] == o) g = (mptr[o][a] + k) % 3;
      if (g >= 0) begin
        mov[o][a]  = 1'b1;
        mdat[o][a] = hq[g];
        mptr[o][a] = (g + 1) % 3;
        for (int j = 0; j < DEPTH - 1; j++) mbuf[g][a][j] = mbuf[g][a][j + 1];
        mcnt[g][a]--;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (si[i] && mcnt[i][p] < DEPTH) begin
        mbuf[i][p][mcnt[i][p]] = di[i];
        mcnt[i][p]++;
      end
    end
    mpol = ~mpol;
  endtask

  task automatic at_neg();
    bit eso;
    logic [63:0] edo;
    @(negedge clk);
    chk("polarity", pol, mpol);
    for (int o = 0; o < 3; o++) begin
      eso = mov[o][mpol] && ro[o];
      edo = eso ? mdat[o][mpol] : mlast[o];
      chk($sformatf("ri%0d", o), ri[o], mcnt[o][mpol] < DEPTH);
      chk($sformatf("so%0d", o), so[o], eso);
      chk($sformatf("do%0d", o), dout[o], edo);
`ifdef ROUTER_STATS_EN
      chk($sformatf("fwd%0d", o), fwd[o], mfwd[o]);
      chk($sformatf("stall%0d", o), stall[o], mstall[o]);
`endif
      if (so[o]) begin
        n_deliv++;
        if (o == 0) log0.push_back(dout[o]);
      end
    end
  endtask

  task automatic fin();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    at_neg();
    fin();
  endtask

  task automatic do_reset();
    rst = 1'b1; si = '0; ro = 3'b111;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int sent, sent2, v1sent;
    bit saw_full;
    int nv0, nv1;
    rst = 1'b1; si = '0; ro = 3'b111;
    for (int i = 0; i < 3; i++) di[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Reset state and pass-through: CW in, hop 3 -> CW out with hop 2 two cycles later
    si = 3'b001; di[0] = mkpkt(1'b0, 8'd3, 32'h11);
    at_neg();
    chk("rst_pol", pol, 1'b0);
    chk("rst_ri", ri, 3'b111);
    chk("rst_so", so, 3'b000);
    chk("rst_do0", dout[0], 64'd0);
    fin();
    si = '0;
    cyc();
    at_neg();
    chk("pt_so", so[0], 1'b1);
    chk("pt_do", dout[0], mkpkt(1'b0, 8'd2, 32'h11));
    chk("pt_pol", pol, 1'b0);
    chk("pt_quiet", {so[1], so[2]}, 2'b00);
    fin();

    // Eject on VC1: CCW in with hop 0 -> PE out unchanged
    si = 3'b010; di[1] = mkpkt(1'b1, 8'd0, 32'h22);
    cyc();
    si = '0;
    cyc();
    at_neg();
    chk("ej_so", so, 3'b100);
    chk("ej_do", dout[2], mkpkt(1'b1, 8'd0, 32'h22));
    fin();
    at_neg();
    chk("ej_one", so[2], 1'b0);
    fin();

    // Fairness: CW and PE both feed the CW output on VC0; CW granted first after reset
    do_reset();
    log0.delete();
    sent = 0; sent2 = 0;
    for (int c = 0; c < 40; c++) begin
      si = '0;
      if (mpol == 1'b0) begin
        si[0] = sent < 4;  di[0] = mkpkt(1'b0, 8'd1, 32'(32'hC00 + sent));
        si[2] = sent2 < 4; di[2] = mkpkt(1'b0, 8'd5, 32'(32'hE00 + sent2));
      end
      at_neg();
      if (si[0] && ri[0]) sent++;
      if (si[2] && ri[2]) sent2++;
      fin();
    end
    chk("fair_cnt", 64'(log0.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      if (k < log0.size())
        chk($sformatf("fair_%0d", k), log0[k],
            (k % 2 == 0) ? mkpkt(1'b0, 8'd0, 32'(32'hC00 + k / 2)) : mkpkt(1'b0, 8'd5, 32'(32'hE00 + k / 2)));

    // Backpressure: CW output blocked; VC0 FIFO fills, VC1 keeps accepting
    do_reset();
    log0.delete();
    ro = 3'b110; sent = 0; v1sent = 0; saw_full = 1'b0;
    for (int c = 0; c < 44; c++) begin
      if (c == 12) ro = 3'b111;
      si = '0;
      if (mpol == 1'b0) begin
        si[0] = sent < 4; di[0] = mkpkt(1'b0, 8'd1, 32'(32'hB00 + sent));
      end else begin
        si[0] = v1sent == 0; di[0] = mkpkt(1'b0, 8'd1, 32'hB1F);
      end
      at_neg();
      if (c < 12 && mpol == 1'b0 && !ri[0]) saw_full = 1'b1;
      if (c >= 7 && c < 12 && mpol == 1'b1) chk("bp_vc1_ri", ri[0], 1'b1);
      if (si[0] && ri[0]) begin
        if (mpol == 1'b0) sent++; else v1sent++;
      end
      if (c == 11) begin
        chk("bp_saw_full", saw_full, 1'b1);
        chk("bp_accepted", 64'(sent), 64'd3);
      end
      fin();
    end
    nv0 = 0; nv1 = 0;
    foreach (log0[k]) begin
      if (log0[k] == mkpkt(1'b0, 8'd0, 32'hB1F)) nv1++;
      else begin
        chk($sformatf("bp_order_%0d", nv0), log0[k], mkpkt(1'b0, 8'd0, 32'(32'hB00 + nv0)));
        nv0++;
      end
    end
    chk("bp_vc0_cnt", 64'(nv0), 64'd4);
    chk("bp_vc1_cnt", 64'(nv1), 64'd1);

    // Reset mid-flight with buffers loaded: nothing stale may emerge
    do_reset();
    ro = 3'b000;
    for (int c = 0; c < 20; c++) begin
      si = 3'($urandom);
      for (int i = 0; i < 3; i++) di[i] = {$urandom, $urandom};
      cyc();
    end
    rst = 1'b1; si = '0;
    cyc();
    rst = 1'b0; ro = 3'b111;
    at_neg();
    chk("mr_pol", pol, 1'b0);
    chk("mr_ri", ri, 3'b111);
    chk("mr_so", so, 3'b000);
    fin();
    n_deliv = 0;
    repeat (12) cyc();
    chk("mr_no_stale", 64'(n_deliv), 64'd0);

    // Random traffic with random backpressure and occasional resets
    do_reset();
    for (int c = 0; c < 800; c++) begin
      si = 3'($urandom);
      for (int k = 0; k < 3; k++) ro[k] = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) begin
        di[i] = {$urandom, $urandom};
        di[i][55:48] = 8'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;

`ifdef ROUTER_STATS_EN
    // Five packets out CCW, link register stalled for three link cycles
    do_reset();
    ro = 3'b101; sent = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 7) ro = 3'b111;
      si = '0;
      si[2] = (mpol == 1'b0) && (sent < 5);
      di[2] = mkpkt(1'b1, 8'd2, 32'(32'h5500 + sent));
      at_neg();
      if (si[2] && ri[2]) sent++;
      fin();
    end
    chk("st_fwd_ccw", fwd[1], 64'd5);
    chk("st_stall_ccw", stall[1], 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
